mmu_psum_drain: RTL

//  Receive end of the MMU partial-sum chain. Sits below the bottom PE row and captures each column's psum_out/en_out.

---
 rtl/mmu_psum_drain.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mmu_psum_drain.sv
// Drain end of the MMU psum chain: deskews the bottom-row column outputs into
// aligned rows and buffers them in a row FIFO behind a valid/ready port.
module mmu_psum_drain #(
    parameter int unsigned COLS         = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned AFULL_THRESH = FIFO_DEPTH - COLS - 1,
    localparam int unsigned PSUM_WIDTH  = 2 * DATA_WIDTH,
    localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH),
    localparam int unsigned LEVEL_W     = PTR_W + 1,
    localparam int unsigned ROW_W       = COLS * PSUM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [COLS-1:0]    col_en,
    input  logic [ROW_W-1:0]   col_psum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ROW_W-1:0]   out_data,
    output logic [LEVEL_W-1:0] level,
    output logic               afull,
    output logic               overflow,
    output logic               skew_err,
    output logic [15:0]        rows_out
);

    logic               flush;
    logic [COLS-1:0]    al_en;
    logic [ROW_W-1:0]   al_psum;

    assign flush = rst | clr;

    // Column c is delayed COLS-c cycles so every column of a row lines up.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int unsigned DEPTH = COLS - c;

        logic [DEPTH-1:0]                 en_sr;
        logic [DEPTH-1:0][PSUM_WIDTH-1:0] ps_sr;

        always_ff @(posedge clk) begin
            if (flush) begin
                en_sr <= '0;
                ps_sr <= '0;
            end else begin
                en_sr[0] <= col_en[c];
                ps_sr[0] <= col_psum[c*PSUM_WIDTH +: PSUM_WIDTH];
                for (int unsigned s = 1; s < DEPTH; s++) begin
                    en_sr[s] <= en_sr[s-1];
                    ps_sr[s] <= ps_sr[s-1];
                end
            end
        end

        assign al_en[c]                              = en_sr[DEPTH-1];
        assign al_psum[c*PSUM_WIDTH +: PSUM_WIDTH]   = ps_sr[DEPTH-1];
    end

    logic [ROW_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [PTR_W-1:0]   wr_ptr_nxt;
    logic [LEVEL_W-1:0] level_nxt;
    logic [ROW_W-1:0]   head_nxt;
    logic               push_req;
    logic               mixed;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;

    // Push/pop decisions and the head row as it will look after this edge.
    always_comb begin
        push_req   = &al_en;
        mixed      = (|al_en) && !push_req;
        pop        = out_valid && out_ready;
        full       = (level == LEVEL_W'(FIFO_DEPTH));
        push       = push_req && (!full || pop);
        drop       = push_req && !push;
        rd_ptr_nxt = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
        wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;
        level_nxt  = level;
        case ({push, pop})
            2'b10:   level_nxt = level + LEVEL_W'(1);
            2'b01:   level_nxt = level - LEVEL_W'(1);
            default: level_nxt = level;
        endcase
        // The new head is the row being written when it lands in the head slot.
        if (push && (rd_ptr_nxt == wr_ptr)) begin
            head_nxt = al_psum;
        end else begin
            head_nxt = mem[rd_ptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= al_psum;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            afull     <= 1'b0;
            overflow  <= 1'b0;
            skew_err  <= 1'b0;
            rows_out  <= '0;
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr_nxt;
            level     <= level_nxt;
            out_valid <= (level_nxt != '0);
            out_data  <= (level_nxt != '0) ? head_nxt : '0;
            afull     <= (level_nxt >= LEVEL_W'(AFULL_THRESH));
            overflow  <= overflow | drop;
            skew_err  <= skew_err | mixed;
            rows_out  <= rows_out + 16'(pop);
        end
    end

endmodule
